// File: rtl/stepper_step_gen.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_step_gen
//  Description : Turns one 32-bit move command into a 50%-duty step square
//                wave plus two direction pins. The half-period is obtained
//                from DIV_NUMERATOR / speed with a bit-serial restoring
//                divider (one quotient bit per clock, no combinational
//                divide). Exactly the commanded number of steps is emitted,
//                then a one-cycle done pulse is raised.
//  Options     : STEP_POSITION_EN - adds the signed 32-bit o_Position
//                accumulator (+1 per step for dir 0, -1 for dir 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_step_gen #(
  parameter int NUM_W         = 24,
  parameter int DIV_NUMERATOR = 1800000,
  parameter int MIN_HALF      = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Cmd_Valid,
  input  logic [31:0] i_Cmd_Word,
  input  logic        i_Abort,
  output logic        o_Cmd_Ready,
  output logic        o_Step,
  output logic        pin1,
  output logic        pin2,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Err,
  output logic        o_Aborted,
  output logic [15:0] o_Steps_Done
`ifdef STEP_POSITION_EN
  ,
  output logic signed [31:0] o_Position
`endif
);

  localparam int              c_CNT_W     = (NUM_W > 1) ? $clog2(NUM_W) : 1;
  localparam logic [NUM_W-1:0] c_NUMERATOR = NUM_W'(DIV_NUMERATOR);
  localparam logic [NUM_W-1:0] c_MIN_HALF  = NUM_W'(MIN_HALF);
  localparam logic [NUM_W-1:0] c_ONE       = NUM_W'(1);
  localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(NUM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIVIDE = 3'd1,
    S_RUN_HI = 3'd2,
    S_RUN_LO = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_State;
  state_t              w_Next_State;

  logic [14:0]         r_Speed;
  logic [15:0]         r_Count;
  logic                r_Pin1;
  logic                r_Pin2;
  logic                r_Step;
  logic                r_Err;
  logic                r_Aborted;
  logic [15:0]         r_Steps_Done;
  logic [NUM_W-1:0]    r_Rem;
  logic [NUM_W-1:0]    r_Quot;
  logic [c_CNT_W-1:0]  r_Div_Cnt;
  logic [NUM_W-1:0]    r_Timer;

  logic                w_Accept;
  logic [14:0]         w_Cmd_Speed;
  logic [15:0]         w_Cmd_Count;
  logic                w_In_Move;
  logic                w_Abort;
  logic [NUM_W:0]      w_Rem_Shift;
  logic [NUM_W:0]      w_Divisor;
  logic                w_Fits;
  logic [NUM_W-1:0]    w_Rem_Sub;
  logic [NUM_W-1:0]    w_Half;
  logic                w_Phase_Last;
  logic                w_Div_Last;
  logic [15:0]         w_Steps_Inc;
  logic                w_Target_Hit;
  logic                w_Step_Complete;

  assign w_Accept    = i_Cmd_Valid && (r_State == S_IDLE);
  assign w_Cmd_Speed = i_Cmd_Word[30:16];
  assign w_Cmd_Count = i_Cmd_Word[15:0];
  assign w_In_Move   = (r_State == S_DIVIDE) || (r_State == S_RUN_HI) ||
                       (r_State == S_RUN_LO);
  assign w_Abort     = i_Abort && w_In_Move;

  // Restoring divide: r_Quot starts as the numerator and shifts its MSB into
  // the partial remainder while the new quotient bit enters from the right.
  // The remainder always stays below the 15-bit divisor, so dropping the top
  // bit of the subtraction result loses nothing.
  assign w_Rem_Shift = {r_Rem, r_Quot[NUM_W-1]};
  assign w_Divisor   = {{(NUM_W + 1 - 15){1'b0}}, r_Speed};
  assign w_Fits      = (w_Rem_Shift >= w_Divisor);
  assign w_Rem_Sub   = w_Rem_Shift[NUM_W-1:0] - w_Divisor[NUM_W-1:0];

  // After DIVIDE r_Quot holds the raw quotient; the clamp is applied on use.
  assign w_Half       = (r_Quot < c_MIN_HALF) ? c_MIN_HALF : r_Quot;
  assign w_Phase_Last = (r_Timer == (w_Half - c_ONE));
  assign w_Div_Last   = (r_Div_Cnt == c_DIV_LAST);
  assign w_Steps_Inc  = r_Steps_Done + 16'd1;
  assign w_Target_Hit = (w_Steps_Inc == r_Count);

  // A step counts only when its low phase finishes without an abort.
  assign w_Step_Complete = (r_State == S_RUN_LO) && !i_Abort && w_Phase_Last;

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State <= S_IDLE;
    end else begin
      r_State <= w_Next_State;
    end
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    w_Next_State = r_State;
    o_Cmd_Ready  = 1'b0;
    o_Busy       = 1'b1;
    o_Done       = 1'b0;
    case (r_State)
      S_IDLE: begin
        o_Cmd_Ready = 1'b1;
        o_Busy      = 1'b0;
        if (w_Accept) begin
          if ((w_Cmd_Speed == 15'd0) || (w_Cmd_Count == 16'd0)) begin
            w_Next_State = S_DONE;
          end else begin
            w_Next_State = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        if (i_Abort) begin
          w_Next_State = S_DONE;
        end else if (w_Div_Last) begin
          w_Next_State = S_RUN_HI;
        end
      end
      S_RUN_HI: begin
        if (i_Abort) begin
          w_Next_State = S_DONE;
        end else if (w_Phase_Last) begin
          w_Next_State = S_RUN_LO;
        end
      end
      S_RUN_LO: begin
        if (i_Abort) begin
          w_Next_State = S_DONE;
        end else if (w_Phase_Last) begin
          w_Next_State = w_Target_Hit ? S_DONE : S_RUN_HI;
        end
      end
      S_DONE: begin
        o_Done       = 1'b1;
        w_Next_State = S_IDLE;
      end
      default: begin
        w_Next_State = S_IDLE;
      end
    endcase
  end

  // Command capture, divider iteration, phase timer and step bookkeeping.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Speed      <= '0;
      r_Count      <= '0;
      r_Pin1       <= 1'b0;
      r_Pin2       <= 1'b0;
      r_Err        <= 1'b0;
      r_Aborted    <= 1'b0;
      r_Steps_Done <= '0;
      r_Rem        <= '0;
      r_Quot       <= '0;
      r_Div_Cnt    <= '0;
      r_Timer      <= '0;
    end else begin
      // The error flag lives exactly for the DONE cycle that follows accept.
      r_Err <= w_Accept && (w_Cmd_Speed == 15'd0);
      if (w_Abort) begin
        r_Aborted <= 1'b1;
      end
      case (r_State)
        S_IDLE: begin
          if (w_Accept) begin
            r_Speed      <= w_Cmd_Speed;
            r_Count      <= w_Cmd_Count;
            r_Pin1       <= i_Cmd_Word[31];
            r_Pin2       <= ~i_Cmd_Word[31];
            r_Aborted    <= 1'b0;
            r_Steps_Done <= '0;
            r_Rem        <= '0;
            r_Quot       <= c_NUMERATOR;
            r_Div_Cnt    <= '0;
            r_Timer      <= '0;
          end
        end
        S_DIVIDE: begin
          r_Quot    <= {r_Quot[NUM_W-2:0], w_Fits};
          r_Rem     <= w_Fits ? w_Rem_Sub : w_Rem_Shift[NUM_W-1:0];
          r_Div_Cnt <= r_Div_Cnt + c_CNT_W'(1);
        end
        S_RUN_HI: begin
          r_Timer <= w_Phase_Last ? '0 : (r_Timer + c_ONE);
        end
        S_RUN_LO: begin
          r_Timer <= w_Phase_Last ? '0 : (r_Timer + c_ONE);
          if (w_Step_Complete) begin
            r_Steps_Done <= w_Steps_Inc;
          end
        end
        default: begin
          r_Timer <= '0;
        end
      endcase
    end
  end

  // Step output follows the RUN_HI state one clock late, which places the
  // first rising edge NUM_W+1 clocks after accept; an abort drops it at once.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Step <= 1'b0;
    end else begin
      r_Step <= (r_State == S_RUN_HI) && !i_Abort;
    end
  end

`ifdef STEP_POSITION_EN
  logic signed [31:0] r_Position;

  // Signed position accumulator; survives accepts and wraps naturally.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Position <= '0;
    end else if (w_Step_Complete) begin
      r_Position <= r_Pin1 ? (r_Position - 32'sd1) : (r_Position + 32'sd1);
    end
  end

  assign o_Position = r_Position;
`else
  // Position tracking is not built in this configuration.
`endif

  assign o_Step       = r_Step;
  assign pin1         = r_Pin1;
  assign pin2         = r_Pin2;
  assign o_Err        = r_Err;
  assign o_Aborted    = r_Aborted;
  assign o_Steps_Done = r_Steps_Done;

endmodule
`default_nettype wire
